// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the asynchronous FIFO pointer handlers.
//   PTR_WIDTH_DEF / DATA_WIDTH_DEF : default address and data widths
//   PTR_MAX                        : widest pointer the Gray helpers accept
//   bin2gray / gray2bin            : pointer code conversions, used by both
//                                    the read- and write-pointer handlers.
// Callers zero-extend a narrower pointer to PTR_MAX bits and truncate the
// result with a size cast. Zero upper bits leave the lower bits of both
// conversions unchanged.
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int PTR_WIDTH_DEF  = 3;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int PTR_MAX        = 16;

  function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] gray);
    logic [PTR_MAX-1:0] bin;
    bin[PTR_MAX-1] = gray[PTR_MAX-1];
    for (int i = PTR_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage : fifo_pkg

// File: rtl/fwft_out_stage.sv
// -----------------------------------------------------------------------------
// fwft_out_stage
// Two-entry first-word-fall-through buffer behind a synchronous-read memory.
// It holds the out register, the skid register and the in-flight flag, and it
// grants read credit so the buffer can never overflow.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   issue_i       : a memory read is issued this cycle (data returns next cycle)
//   rd_data_i     : memory read data, valid the cycle after issue_i
//   m_ready_i     : consumer ready
//   credit_ok_o   : room for one more read issued this cycle
//   m_valid_o     : out register holds a word
//   m_data_o      : out register data
// -----------------------------------------------------------------------------
module fwft_out_stage #(
  parameter int Data_Width = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_i,
  input  logic [Data_Width-1:0] rd_data_i,
  input  logic                  m_ready_i,
  output logic                  credit_ok_o,
  output logic                  m_valid_o,
  output logic [Data_Width-1:0] m_data_o
);

  logic                  out_valid_q, out_valid_d;
  logic [Data_Width-1:0] out_data_q,  out_data_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [Data_Width-1:0] skid_data_q,  skid_data_d;
  logic                  inflight_q;
  logic                  pop;
  logic [1:0]            occupancy;

  assign pop = out_valid_q && m_ready_i;

  // Words held or on their way, minus the one leaving this cycle. Fewer than
  // two means one more read can be issued without ever needing a third slot.
  // A pop implies out_valid_q, so the subtraction cannot underflow.
  assign occupancy   = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, inflight_q}
                     - {1'b0, pop};
  assign credit_ok_o = (occupancy < 2'd2);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (pop && skid_valid_q) begin
      // The skid word is older than any returning word: it moves to out first.
      out_valid_d  = 1'b1;
      out_data_d   = skid_data_q;
      skid_valid_d = inflight_q;
      if (inflight_q) begin
        skid_data_d = rd_data_i;
      end
    end else if (!out_valid_q || pop) begin
      // Out slot free (or freeing) and skid empty: the returning word goes to out.
      out_valid_d = inflight_q;
      if (inflight_q) begin
        out_data_d = rd_data_i;
      end
    end else if (inflight_q) begin
      // Out is stalled: park the returning word in skid.
      skid_valid_d = 1'b1;
      skid_data_d  = rd_data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      inflight_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      inflight_q   <= issue_i;
    end
  end

  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

endmodule : fwft_out_stage

// File: rtl/rptr_fwft_handler.sv
// -----------------------------------------------------------------------------
// rptr_fwft_handler
// Read-domain pointer handler of the asynchronous FIFO with a first-word-fall-
// through output stream. It advances the binary/Gray read pointers, drives the
// synchronous-read memory port and reports empty, almost-empty and occupancy.
//   rclk, rrst    : read clock, synchronous active-high reset
//   g_wptr_sync   : Gray write pointer, already synchronised into rclk
//   rd_en         : memory read strobe (combinational)
//   rd_addr       : memory read address
//   rd_data       : memory read data, valid the cycle after rd_en
//   b_rptr/g_rptr : binary / Gray read pointers (registered)
//   empty         : no unread words in the memory (registered)
//   almost_empty  : rd_level <= Almost_Empty_Th (registered)
//   rd_level      : unread words in the memory (registered)
//   m_valid/m_ready/m_data : output stream
// empty describes the memory only; a word can still sit in the output buffer.
// -----------------------------------------------------------------------------
module rptr_fwft_handler
  import fifo_pkg::*;
#(
  parameter int Ptr_Width       = PTR_WIDTH_DEF,
  parameter int Data_Width      = DATA_WIDTH_DEF,
  parameter int Almost_Empty_Th = 1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [Ptr_Width:0]    g_wptr_sync,
  output logic                  rd_en,
  output logic [Ptr_Width-1:0]  rd_addr,
  input  logic [Data_Width-1:0] rd_data,
  output logic [Ptr_Width:0]    b_rptr,
  output logic [Ptr_Width:0]    g_rptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [Ptr_Width:0]    rd_level,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [Data_Width-1:0] m_data
);

  localparam logic [Ptr_Width:0] AE_TH = (Ptr_Width + 1)'(Almost_Empty_Th);

  logic [Ptr_Width:0] b_rptr_q, b_rptr_d;
  logic [Ptr_Width:0] g_rptr_q, g_rptr_d;
  logic [Ptr_Width:0] rd_level_q, rd_level_d;
  logic               empty_q, empty_d;
  logic               almost_empty_q, almost_empty_d;
  logic [Ptr_Width:0] wbin;
  logic               credit_ok;

  // A read is issued whenever the memory holds a word and the output buffer
  // has a free slot for it by the time it returns.
  assign rd_en = !empty_q && credit_ok;

  assign b_rptr_d = b_rptr_q + {{Ptr_Width{1'b0}}, rd_en};
  assign g_rptr_d = (Ptr_Width + 1)'(bin2gray(PTR_MAX'(b_rptr_d)));
  assign wbin     = (Ptr_Width + 1)'(gray2bin(PTR_MAX'(g_wptr_sync)));

  // Modular difference: the extra MSB distinguishes full (2**Ptr_Width)
  // from empty (0) when the lower bits match.
  assign rd_level_d     = wbin - b_rptr_d;
  assign empty_d        = (g_rptr_d == g_wptr_sync);
  assign almost_empty_d = (rd_level_d <= AE_TH);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      b_rptr_q       <= '0;
      g_rptr_q       <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      b_rptr_q       <= b_rptr_d;
      g_rptr_q       <= g_rptr_d;
      rd_level_q     <= rd_level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  fwft_out_stage #(
    .Data_Width (Data_Width)
  ) u_out_stage (
    .clk_i       (rclk),
    .rst_i       (rrst),
    .issue_i     (rd_en),
    .rd_data_i   (rd_data),
    .m_ready_i   (m_ready),
    .credit_ok_o (credit_ok),
    .m_valid_o   (m_valid),
    .m_data_o    (m_data)
  );

  assign rd_addr      = b_rptr_q[Ptr_Width-1:0];
  assign b_rptr       = b_rptr_q;
  assign g_rptr       = g_rptr_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_level     = rd_level_q;

endmodule : rptr_fwft_handler

// File: tb/tb_rptr_fwft_handler.sv
// -----------------------------------------------------------------------------
// tb_rptr_fwft_handler
// Bench for rptr_fwft_handler with default parameters (8-deep, 8-bit). The
// bench plays the write side: it fills a memory model, advances its own write
// pointer and presents it in Gray code. Every written word is pushed to a
// scoreboard queue; a monitor pops and compares on every stream handshake.
// Stimulus changes 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_rptr_fwft_handler;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [3:0] g_wptr_sync;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] b_rptr;
  logic [3:0] g_rptr;
  logic       empty;
  logic       almost_empty;
  logic [3:0] rd_level;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;

  int vectors     = 0;
  int miscompares = 0;
  int popped      = 0;

  logic [7:0] mem [8];
  logic [3:0] wptr;
  logic [7:0] sb [$];

  always #5 rclk = ~rclk;

  rptr_fwft_handler dut (
    .rclk         (rclk),
    .rrst         (rrst),
    .g_wptr_sync  (g_wptr_sync),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_level     (rd_level),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data)
  );

  // Synchronous-read memory: data is valid the cycle after rd_en.
  always @(posedge rclk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Stream monitor: every handshake must deliver the oldest written word.
  always @(negedge rclk) begin
    logic [7:0] exp_d;
    if (!rrst && m_valid && m_ready) begin
      vectors++;
      popped++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL stream_pop: got word %h, expected no word", m_data);
      end else begin
        exp_d = sb.pop_front();
        if (m_data !== exp_d) begin
          miscompares++;
          $display("FAIL stream_data: got %h, expected %h", m_data, exp_d);
        end
      end
    end
  end

  task automatic drive_edge();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wptr[2:0]] = d;
    wptr           = wptr + 4'd1;
    g_wptr_sync    = wptr ^ (wptr >> 1);
    sb.push_back(d);
  endtask

  task automatic do_reset();
    drive_edge();
    rrst        = 1'b1;
    m_ready     = 1'b0;
    wptr        = '0;
    g_wptr_sync = '0;
    sb.delete();
    repeat (3) @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    rrst        = 1'b1;
    m_ready     = 1'b0;
    wptr        = '0;
    g_wptr_sync = '0;
    repeat (3) @(posedge rclk);
    @(negedge rclk);
    if (empty !== 1'b1)        begin miscompares++; $display("FAIL reset_empty: got %b, expected 1", empty); end
    vectors++;
    if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_almost_empty: got %b, expected 1", almost_empty); end
    vectors++;
    if (m_valid !== 1'b0)      begin miscompares++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
    vectors++;
    if (b_rptr !== 4'd0)       begin miscompares++; $display("FAIL reset_b_rptr: got %h, expected 0", b_rptr); end
    vectors++;
    if (g_rptr !== 4'd0)       begin miscompares++; $display("FAIL reset_g_rptr: got %h, expected 0", g_rptr); end
    vectors++;
    if (rd_level !== 4'd0)     begin miscompares++; $display("FAIL reset_rd_level: got %h, expected 0", rd_level); end
    vectors++;
    if (m_data !== 8'h00)      begin miscompares++; $display("FAIL reset_m_data: got %h, expected 00", m_data); end
    vectors++;
    drive_edge();
    rrst = 1'b0;
  endtask

  task automatic test_single_word();
    int base;
    do_reset();
    drive_edge();
    base = popped;
    write_word(8'hA5);
    @(negedge rclk);  // before E1
    if (empty !== 1'b1) begin miscompares++; $display("FAIL single_empty_e0: got %b, expected 1", empty); end
    vectors++;
    @(negedge rclk);  // after E1
    if (empty !== 1'b0)   begin miscompares++; $display("FAIL single_empty_e1: got %b, expected 0", empty); end
    vectors++;
    if (rd_en !== 1'b1)   begin miscompares++; $display("FAIL single_rd_en_e1: got %b, expected 1", rd_en); end
    vectors++;
    if (rd_addr !== 3'd0) begin miscompares++; $display("FAIL single_rd_addr: got %h, expected 0", rd_addr); end
    vectors++;
    @(negedge rclk);  // after E2
    if (rd_en !== 1'b0)   begin miscompares++; $display("FAIL single_rd_en_e2: got %b, expected 0", rd_en); end
    vectors++;
    if (b_rptr !== 4'd1)  begin miscompares++; $display("FAIL single_b_rptr: got %h, expected 1", b_rptr); end
    vectors++;
    if (empty !== 1'b1)   begin miscompares++; $display("FAIL single_empty_e2: got %b, expected 1", empty); end
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_m_valid_e2: got %b, expected 0", m_valid); end
    vectors++;
    @(negedge rclk);  // after E3
    if (m_valid !== 1'b1) begin miscompares++; $display("FAIL single_m_valid_e3: got %b, expected 1", m_valid); end
    vectors++;
    if (m_data !== 8'hA5) begin miscompares++; $display("FAIL single_m_data_e3: got %h, expected a5", m_data); end
    vectors++;
    drive_edge();
    m_ready = 1'b1;
    repeat (4) @(negedge rclk);
    if (popped - base !== 1) begin miscompares++; $display("FAIL single_pop_count: got %0d, expected 1", popped - base); end
    vectors++;
    if (m_valid !== 1'b0)    begin miscompares++; $display("FAIL single_drained: got m_valid %b, expected 0", m_valid); end
    vectors++;
  endtask

  task automatic test_stream8();
    logic [3:0] exp_level;
    do_reset();
    drive_edge();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i));
    if (g_wptr_sync !== 4'b1100) begin miscompares++; $display("FAIL stream8_gray8: got %b, expected 1100", g_wptr_sync); end
    vectors++;
    @(negedge rclk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge rclk);
      exp_level = (k <= 9) ? 4'(9 - k) : 4'd0;
      if (rd_level !== exp_level) begin
        miscompares++; $display("FAIL stream8_level cycle %0d: got %0d, expected %0d", k, rd_level, exp_level);
      end
      vectors++;
      if (almost_empty !== (exp_level <= 4'd1)) begin
        miscompares++; $display("FAIL stream8_almost_empty cycle %0d: got %b, expected %b", k, almost_empty, exp_level <= 4'd1);
      end
      vectors++;
      if (m_valid !== (k >= 3 && k <= 10)) begin
        miscompares++; $display("FAIL stream8_m_valid cycle %0d: got %b, expected %b", k, m_valid, (k >= 3 && k <= 10));
      end
      vectors++;
      if (k == 1) begin
        // Full at pointer level: MSB differs, lower bits equal.
        if (empty !== 1'b0) begin miscompares++; $display("FAIL stream8_full_empty: got %b, expected 0", empty); end
        vectors++;
      end
    end
    if (sb.size() != 0) begin miscompares++; $display("FAIL stream8_leftover: got %0d words, expected 0", sb.size()); end
    vectors++;
  endtask

  task automatic test_backpressure();
    int pulses;
    int base;
    do_reset();
    drive_edge();
    pulses = 0;
    base   = popped;
    for (int i = 0; i < 5; i++) write_word(8'hB0 + 8'(i));
    @(negedge rclk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge rclk);
      if (rd_en) pulses++;
      if (k >= 3) begin
        if (m_valid !== 1'b1 || m_data !== 8'hB0) begin
          miscompares++; $display("FAIL bp_frozen cycle %0d: got valid %b data %h, expected valid 1 data b0", k, m_valid, m_data);
        end
        vectors++;
      end
    end
    if (pulses > 2)        begin miscompares++; $display("FAIL bp_rd_en_pulses: got %0d, expected at most 2", pulses); end
    vectors++;
    if (rd_level !== 4'd3) begin miscompares++; $display("FAIL bp_rd_level: got %0d, expected 3", rd_level); end
    vectors++;
    drive_edge();
    m_ready = 1'b1;
    repeat (12) @(negedge rclk);
    if (popped - base !== 5) begin miscompares++; $display("FAIL bp_pop_count: got %0d, expected 5", popped - base); end
    vectors++;
    if (sb.size() != 0)      begin miscompares++; $display("FAIL bp_leftover: got %0d words, expected 0", sb.size()); end
    vectors++;
  endtask

  task automatic test_wrap();
    int         written;
    logic [3:0] prev_b;
    logic [3:0] prev_g;
    logic [2:0] prev_a;
    logic       wrap_b;
    logic       wrap_a;
    do_reset();
    written = 0;
    prev_b  = '0;
    prev_g  = '0;
    prev_a  = '0;
    wrap_b  = 1'b0;
    wrap_a  = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      drive_edge();
      m_ready = 1'b1;
      if (written < 20 && 4'(wptr - b_rptr) < 4'd8) begin
        write_word(8'h40 + 8'(written));
        written++;
      end
      @(negedge rclk);
      if (b_rptr !== prev_b) begin
        if (b_rptr !== 4'(prev_b + 4'd1)) begin
          miscompares++; $display("FAIL wrap_b_step: got %h, expected %h", b_rptr, 4'(prev_b + 4'd1));
        end
        vectors++;
        if ($countones(g_rptr ^ prev_g) != 1) begin
          miscompares++; $display("FAIL wrap_gray_step: got %b after %b, expected one bit change", g_rptr, prev_g);
        end
        vectors++;
        if (g_rptr !== (b_rptr ^ (b_rptr >> 1))) begin
          miscompares++; $display("FAIL wrap_gray_code: got %b, expected %b", g_rptr, b_rptr ^ (b_rptr >> 1));
        end
        vectors++;
        if (prev_b == 4'd15 && b_rptr == 4'd0) wrap_b = 1'b1;
        if (prev_a == 3'd7 && rd_addr == 3'd0) wrap_a = 1'b1;
      end
      prev_b = b_rptr;
      prev_g = g_rptr;
      prev_a = rd_addr;
      if (written == 20 && sb.size() == 0 && !m_valid) break;
    end
    if (wrap_b !== 1'b1) begin miscompares++; $display("FAIL wrap_b_rptr: got no 15->0 wrap, expected one"); end
    vectors++;
    if (wrap_a !== 1'b1) begin miscompares++; $display("FAIL wrap_rd_addr: got no 7->0 wrap, expected one"); end
    vectors++;
    if (sb.size() != 0 || written != 20) begin
      miscompares++; $display("FAIL wrap_drain: got %0d written %0d left, expected 20 written 0 left", written, sb.size());
    end
    vectors++;
  endtask

  task automatic test_reset_inflight();
    int base;
    do_reset();
    drive_edge();
    write_word(8'hE0);
    write_word(8'hE1);
    @(negedge rclk);  // before E1
    @(negedge rclk);  // after E1: first read issued
    @(negedge rclk);  // after E2: first word in flight
    #1;
    rrst = 1'b1;
    @(negedge rclk);  // after the reset edge
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_if_m_valid: got %b, expected 0", m_valid); end
    vectors++;
    if (m_data !== 8'h00) begin miscompares++; $display("FAIL rst_if_m_data: got %h, expected 00", m_data); end
    vectors++;
    if (b_rptr !== 4'd0 || g_rptr !== 4'd0) begin
      miscompares++; $display("FAIL rst_if_pointers: got b %h g %h, expected 0 0", b_rptr, g_rptr);
    end
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL rst_if_empty: got %b, expected 1", empty); end
    vectors++;
    // The write side is reset together with the read side.
    wptr        = '0;
    g_wptr_sync = '0;
    sb.delete();
    base = popped;
    repeat (2) @(negedge rclk);
    drive_edge();
    rrst    = 1'b0;
    m_ready = 1'b1;
    write_word(8'h77);
    repeat (8) @(negedge rclk);
    if (popped - base !== 1) begin miscompares++; $display("FAIL rst_if_pop_count: got %0d, expected 1", popped - base); end
    vectors++;
    if (sb.size() != 0)      begin miscompares++; $display("FAIL rst_if_leftover: got %0d words, expected 0", sb.size()); end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_stream8();
    test_backpressure();
    test_wrap();
    test_reset_inflight();
    drive_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_rptr_fwft_handler
